// File: rtl/game_pkg.sv
//------------------------------------------------------------------------------
// game_pkg: state encoding, BCD limits and ARM default shared by the round logic.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_TENS       = 4'd9;
  localparam logic [3:0] BCD_MAX_ONES       = 4'd9;
  localparam int         ARM_CYCLES_DEFAULT = 50_000_000;

endpackage

`default_nettype wire

// File: rtl/bcd_counter2.sv
//------------------------------------------------------------------------------
// bcd_counter2: two-digit BCD counter saturating at 00 and 99; clr has priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_counter2
  import game_pkg::*;
(
  input  logic       Clck,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] r_tens;
  logic [3:0] r_ones;

  always_ff @(posedge Clck) begin
    if (!reset || clr) begin
      r_tens <= 4'd0;
      r_ones <= 4'd0;
    end else if (inc) begin
      if (r_tens == BCD_MAX_TENS && r_ones == BCD_MAX_ONES) begin
        r_tens <= r_tens;
        r_ones <= r_ones;
      end else if (r_ones == BCD_MAX_ONES) begin
        r_ones <= 4'd0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end else if (dec) begin
      if (r_tens == 4'd0 && r_ones == 4'd0) begin
        r_tens <= r_tens;
        r_ones <= r_ones;
      end else if (r_ones == 4'd0) begin
        r_ones <= BCD_MAX_ONES;
        r_tens <= r_tens - 4'd1;
      end else begin
        r_ones <= r_ones - 4'd1;
      end
    end
  end

  assign tens = r_tens;
  assign ones = r_ones;

endmodule

`default_nettype wire

// File: rtl/game_round_ctrl.sv
//------------------------------------------------------------------------------
// game_round_ctrl: IDLE/ARM/RUN/DONE round sequencer with BCD score and best.
// Optional miss penalty: GAME_ROUND_CTRL_MISS_PENALTY_EN.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module game_round_ctrl
  import game_pkg::*;
#(
  parameter int ARM_CYCLES = ARM_CYCLES_DEFAULT
) (
  input  logic       Clck,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       timer_signal,
  input  logic       hit,
  input  logic       miss,
  output logic       timer_reset,
  output logic       game_start,
  output logic       game_done,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [3:0] best_tens,
  output logic [3:0] best_ones,
  output logic [1:0] state
);

  localparam int            CW       = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [CW-1:0] ARM_LAST = CW'(ARM_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_arm_cnt;
  logic [CW-1:0] w_arm_cnt_next;
  logic          r_btn_q;
  logic          r_timer_reset;
  logic          r_game_start;
  logic          r_game_done;
  logic          r_round_end;
  logic [3:0]    r_best_tens;
  logic [3:0]    r_best_ones;
  logic          w_start_edge;
  logic          w_start_round;
  logic          w_in_run;
  logic          w_inc;
  logic          w_dec;

  assign w_start_edge = start_btn & ~r_btn_q;
  assign w_in_run     = (r_state == ST_RUN);

`ifdef GAME_ROUND_CTRL_MISS_PENALTY_EN
  assign w_inc = w_in_run & hit & ~miss;
  assign w_dec = w_in_run & miss & ~hit;
`else
  logic w_unused_miss;
  assign w_unused_miss = miss;
  assign w_inc         = w_in_run & hit;
  assign w_dec         = 1'b0;
`endif

  always_comb begin
    w_state_next   = r_state;
    w_arm_cnt_next = r_arm_cnt;
    w_start_round  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_edge) begin
          w_state_next   = ST_ARM;
          w_arm_cnt_next = '0;
          w_start_round  = 1'b1;
        end
      end
      ST_ARM: begin
        if (r_arm_cnt == ARM_LAST) begin
          w_state_next   = ST_RUN;
          w_arm_cnt_next = '0;
        end else begin
          w_arm_cnt_next = r_arm_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (timer_signal) w_state_next = ST_DONE;
      end
      default: ;
    endcase
  end

  // Best is compared one cycle after RUN->DONE so the final-cycle hit is already in the score.
  always_ff @(posedge Clck) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_arm_cnt     <= '0;
      r_btn_q       <= 1'b1;
      r_timer_reset <= 1'b0;
      r_game_start  <= 1'b0;
      r_game_done   <= 1'b1;
      r_round_end   <= 1'b0;
      r_best_tens   <= 4'd0;
      r_best_ones   <= 4'd0;
    end else begin
      r_state       <= w_state_next;
      r_arm_cnt     <= w_arm_cnt_next;
      r_btn_q       <= start_btn;
      r_timer_reset <= w_start_round;
      r_game_start  <= (r_state == ST_RUN);
      r_game_done   <= (r_state == ST_DONE);
      r_round_end   <= w_in_run & timer_signal;
      if (r_round_end && ({score_tens, score_ones} > {r_best_tens, r_best_ones})) begin
        r_best_tens <= score_tens;
        r_best_ones <= score_ones;
      end
    end
  end

  bcd_counter2 u_score (
    .Clck  (Clck),
    .reset (reset),
    .inc   (w_inc),
    .dec   (w_dec),
    .clr   (w_start_round),
    .tens  (score_tens),
    .ones  (score_ones)
  );

  assign timer_reset = r_timer_reset;
  assign game_start  = r_game_start;
  assign game_done   = r_game_done;
  assign best_tens   = r_best_tens;
  assign best_ones   = r_best_ones;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_game_round_ctrl.sv
//------------------------------------------------------------------------------
// tb_game_round_ctrl: directed self-checking bench for game_round_ctrl, ARM_CYCLES=4.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_round_ctrl;

  logic       Clck = 1'b0;
  logic       reset;
  logic       start_btn;
  logic       timer_signal;
  logic       hit;
  logic       miss;
  logic       timer_reset;
  logic       game_start;
  logic       game_done;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [3:0] best_tens;
  logic [3:0] best_ones;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  game_round_ctrl #(.ARM_CYCLES(4)) dut (
    .Clck         (Clck),
    .reset        (reset),
    .start_btn    (start_btn),
    .timer_signal (timer_signal),
    .hit          (hit),
    .miss         (miss),
    .timer_reset  (timer_reset),
    .game_start   (game_start),
    .game_done    (game_done),
    .score_tens   (score_tens),
    .score_ones   (score_ones),
    .best_tens    (best_tens),
    .best_ones    (best_ones),
    .state        (state)
  );

  always #5 Clck = ~Clck;

  task automatic tick;
    @(posedge Clck);
    #1;
  endtask

  // Start edge now; four ARM cycles later the DUT is in RUN.
  task automatic start_round;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    repeat (4) tick();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL start_round_run got %0d exp 2", state); end
  endtask

  task automatic end_round;
    timer_signal = 1'b1;
    tick();
    timer_signal = 1'b0;
    tick();
  endtask

  task automatic pulse_hits(input int n);
    hit = 1'b1;
    repeat (n) tick();
    hit = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start_btn = 1'b1; timer_signal = 1'b0; hit = 1'b0; miss = 1'b0;
    repeat (2) tick();
    checks++;
    if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++;
    if (game_done !== 1'b1) begin errors++; $display("FAIL reset_game_done got %0b exp 1", game_done); end
    checks++;
    if ({game_start, timer_reset} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {game_start, timer_reset}); end
    checks++;
    if ({score_tens, score_ones, best_tens, best_ones} !== 16'h0000) begin
      errors++; $display("FAIL reset_scores got %h exp 0000", {score_tens, score_ones, best_tens, best_ones});
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (state !== 2'd0) begin errors++; $display("FAIL held_button_no_arm got %0d exp 0", state); end
    end
    start_btn = 1'b0;
    tick();
  endtask

  task automatic test_round_timing;
    start_btn = 1'b1;                       // cycle N
    tick();                                 // N+1
    checks++;
    if ({state, timer_reset} !== 3'b011) begin errors++; $display("FAIL arm_entry got %b exp 011", {state, timer_reset}); end
    start_btn = 1'b0;
    tick();                                 // N+2
    checks++;
    if ({state, timer_reset} !== 3'b010) begin errors++; $display("FAIL timer_reset_once got %b exp 010", {state, timer_reset}); end
    start_btn = 1'b1;                       // edge in ARM is ignored
    tick();                                 // N+3
    start_btn = 1'b0;
    tick();                                 // N+4
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL arm_hold got %0d exp 1", state); end
    tick();                                 // N+5
    checks++;
    if ({state, game_start} !== 3'b100) begin errors++; $display("FAIL run_entry got %b exp 100", {state, game_start}); end
    tick();                                 // N+6
    checks++;
    if ({game_start, game_done} !== 2'b10) begin errors++; $display("FAIL game_start_rise got %b exp 10", {game_start, game_done}); end
    start_btn = 1'b1;                       // edge in RUN is ignored
    tick();
    start_btn = 1'b0;
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL run_ignores_start got %0d exp 2", state); end
    timer_signal = 1'b1;
    tick();
    timer_signal = 1'b0;
    checks++;
    if ({state, game_start, game_done} !== 4'b1110) begin
      errors++; $display("FAIL done_entry got %b exp 1110", {state, game_start, game_done});
    end
    tick();
    checks++;
    if ({state, game_start, game_done} !== 4'b1101) begin
      errors++; $display("FAIL game_start_fall got %b exp 1101", {state, game_start, game_done});
    end
    timer_signal = 1'b1;                    // no effect in DONE
    repeat (2) tick();
    timer_signal = 1'b0;
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL done_hold got %0d exp 3", state); end
  endtask

  task automatic test_best;
    start_round();
    pulse_hits(7);
    hit = 1'b1; timer_signal = 1'b1;
    tick();
    hit = 1'b0; timer_signal = 1'b0;
    checks++;
    if ({state, score_tens, score_ones} !== 10'h308) begin
      errors++; $display("FAIL final_hit_counted got %h exp 308", {state, score_tens, score_ones});
    end
    tick();
    checks++;
    if ({best_tens, best_ones} !== 8'h08) begin errors++; $display("FAIL best_round1 got %h exp 08", {best_tens, best_ones}); end
    pulse_hits(2);
    checks++;
    if ({score_tens, score_ones} !== 8'h08) begin errors++; $display("FAIL done_ignores_hit got %h exp 08", {score_tens, score_ones}); end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    checks++;
    if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("FAIL score_clear_arm got %h exp 00", {score_tens, score_ones}); end
    pulse_hits(2);
    checks++;
    if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("FAIL arm_ignores_hit got %h exp 00", {score_tens, score_ones}); end
    repeat (2) tick();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL round2_run got %0d exp 2", state); end
    pulse_hits(5);
    end_round();
    checks++;
    if ({score_tens, score_ones, best_tens, best_ones} !== 16'h0508) begin
      errors++; $display("FAIL best_round2 got %h exp 0508", {score_tens, score_ones, best_tens, best_ones});
    end
  endtask

  task automatic test_score;
    start_round();
    pulse_hits(12);
    checks++;
    if ({score_tens, score_ones} !== 8'h12) begin errors++; $display("FAIL score_12 got %h exp 12", {score_tens, score_ones}); end
    pulse_hits(87);
    checks++;
    if ({score_tens, score_ones} !== 8'h99) begin errors++; $display("FAIL score_99 got %h exp 99", {score_tens, score_ones}); end
    pulse_hits(3);
    checks++;
    if ({score_tens, score_ones} !== 8'h99) begin errors++; $display("FAIL score_saturate got %h exp 99", {score_tens, score_ones}); end
    end_round();
    checks++;
    if ({best_tens, best_ones} !== 8'h99) begin errors++; $display("FAIL best_99 got %h exp 99", {best_tens, best_ones}); end
  endtask

  task automatic test_hit_miss;
    logic [7:0] exp_both;
    logic [7:0] exp_miss10;
    int         n_to_10;
`ifdef GAME_ROUND_CTRL_MISS_PENALTY_EN
    exp_both = 8'h02; exp_miss10 = 8'h09; n_to_10 = 8;
`else
    exp_both = 8'h03; exp_miss10 = 8'h10; n_to_10 = 7;
`endif
    start_round();
    miss = 1'b1;
    tick();
    miss = 1'b0;
    checks++;
    if ({score_tens, score_ones} !== 8'h00) begin errors++; $display("FAIL miss_at_00 got %h exp 00", {score_tens, score_ones}); end
    pulse_hits(2);
    hit = 1'b1; miss = 1'b1;
    tick();
    hit = 1'b0; miss = 1'b0;
    checks++;
    if ({score_tens, score_ones} !== exp_both) begin errors++; $display("FAIL hit_and_miss got %h exp %h", {score_tens, score_ones}, exp_both); end
    pulse_hits(n_to_10);
    checks++;
    if ({score_tens, score_ones} !== 8'h10) begin errors++; $display("FAIL score_10 got %h exp 10", {score_tens, score_ones}); end
    miss = 1'b1;
    tick();
    miss = 1'b0;
    checks++;
    if ({score_tens, score_ones} !== exp_miss10) begin errors++; $display("FAIL miss_at_10 got %h exp %h", {score_tens, score_ones}, exp_miss10); end
    end_round();
    checks++;
    if ({best_tens, best_ones} !== 8'h99) begin errors++; $display("FAIL best_kept_99 got %h exp 99", {best_tens, best_ones}); end
  endtask

  task automatic test_reset_mid_run;
    start_round();
    pulse_hits(3);
    checks++;
    if ({score_tens, score_ones} !== 8'h03) begin errors++; $display("FAIL score_03 got %h exp 03", {score_tens, score_ones}); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({state, score_tens, score_ones, best_tens, best_ones} !== 18'h00000) begin
      errors++; $display("FAIL reset_mid_run got %h exp 00000", {state, score_tens, score_ones, best_tens, best_ones});
    end
    checks++;
    if (game_done !== 1'b1) begin errors++; $display("FAIL reset_mid_done got %0b exp 1", game_done); end
    hit = 1'b1; timer_signal = 1'b1;
    repeat (3) tick();
    hit = 1'b0; timer_signal = 1'b0;
    checks++;
    if ({state, score_tens, score_ones} !== 10'h000) begin
      errors++; $display("FAIL idle_ignores_hit got %h exp 000", {state, score_tens, score_ones});
    end
  endtask

  initial begin
    test_reset();
    test_round_timing();
    test_best();
    test_score();
    test_hit_miss();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Single clock and reset SHALL be used: one clock; reset is synchronous and active-low.
REQ-002 Parameter ARM_CYCLES, 50_000_000, clock cycles spent in ARM before the round starts (1 s at 50 MHz); legal range >= 1.
REQ-003 Clck  input  1  system clock, all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start_btn  input  1  level input; its rising edge requests a new round.
REQ-006 timer_signal  input  1  round-time-expired level from the game timer.
REQ-007 hit  input  1  one-cycle pulse: mole whacked.
REQ-008 miss  input  1  one-cycle pulse: wrong hole whacked.
REQ-009 timer_reset  output  1  one-cycle pulse that clears the game timer.
REQ-010 game_start  output  1  high for the whole of RUN; drives the timer's game_start.
REQ-011 game_done  output  1  high for the whole of DONE; drives the timer's enable.
REQ-012 score_tens, score_ones  output  4 each  current round score, BCD.
REQ-013 best_tens, best_ones  output  4 each  best score since reset, BCD.
REQ-014 state  output  2  current FSM state encoding.

Function
REQ-015 FSM states SHALL be IDLE=0, ARM=1, RUN=2, DONE=3.
REQ-016 Start edge SHALL be detected with a one-flop delay: edge = start_btn & ~start_btn_q.
REQ-017 IDLE or DONE plus start edge SHALL go to ARM next cycle, clear score to 00, and pulse timer_reset in the first ARM cycle only.
REQ-018 ARM SHALL last exactly ARM_CYCLES cycles, then go to RUN; start edges during ARM SHALL be ignored.
REQ-019 In RUN, timer_signal high SHALL move the FSM to DONE next cycle; start edges in RUN SHALL be ignored.
REQ-020 DONE SHALL hold until a start edge arrives.
REQ-021 game_start and game_done SHALL be registered decodes of RUN and DONE: never both high, each with one cycle latency from the state change.
REQ-022 Hits and misses SHALL be counted only in cycles where state==RUN, including the cycle in which timer_signal is first seen high; they SHALL be ignored in every other state.
REQ-023 A hit SHALL increment the score as a 2-digit BCD value; ones 9->0 with carry into tens; the score SHALL saturate at 99.
REQ-024 hit and miss in the same cycle SHALL leave the score unchanged.
REQ-025 On the RUN->DONE transition, the best score SHALL load the final score, including any hit in that same cycle, if that score is strictly greater than best.
REQ-026 timer_signal high in IDLE, ARM or DONE SHALL have no effect.

Reset
REQ-027 reset low on a clock edge SHALL set state=IDLE, score=00, best=00, timer_reset=0, game_start=0, game_done=1, start_btn_q=1 and the ARM counter to 0.
REQ-028 Reset mid-round SHALL abort to IDLE with the above values. Because start_btn_q resets to 1, a button already held during reset SHALL NOT start a round.

Configuration
REQ-029 Macro GAME_ROUND_CTRL_MISS_PENALTY_EN SHALL select miss handling.
- Defined: a miss alone in RUN decrements the score in BCD, saturating at 00.
- Undefined: miss is ignored entirely, and REQ-024 reduces to "hit counts".

Structure
REQ-030 Shared package game_pkg SHALL hold the state encoding constants, BCD_MAX_TENS=9, BCD_MAX_ONES=9, and the ARM_CYCLES default.
REQ-031 Sub-module bcd_counter2 SHALL implement the 2-digit saturating BCD counter:
- inputs: inc, dec, clr;
- outputs: tens, ones;
- instantiated once for the current score.
REQ-032 The best-score register and comparator SHALL live in the top module.

Verification
REQ-033 Bench setup: ARM_CYCLES=4.
- Stimulus: reset low 2 cycles, then release; hold start_btn high from before reset release.
- Required response: state=0, game_done=1, and no ARM entry until start_btn falls and rises again.
REQ-034 Round timing:
- Stimulus: start edge at cycle N.
- Required response: timer_reset=1 only in cycle N+1, game_start rises at N+6, and game_start falls one cycle after state==DONE, following timer_signal.
REQ-035 Score carry and saturation:
- Stimulus: 12 hits in RUN.
- Required response: score=12.
- Then: 90 more hits -> score=99 (saturated).
REQ-036 Simultaneous hit and miss in RUN -> score unchanged.
- With GAME_ROUND_CTRL_MISS_PENALTY_EN: miss at score 00 -> stays 00; miss at 10 -> 09.
REQ-037 Best score update:
- Round 1 ends with score 07, hit in the timer_signal cycle -> best=08.
- Round 2 ends with 05 -> best stays 08, and score clears to 00 at ARM entry.
REQ-038 Reset mid-RUN at score 03 -> IDLE next cycle, score=00, best=00; hits during IDLE are ignored.
